cp0_intc: RTL and testbench

Coprocessor-0 interrupt and exception controller for the pipelined MIPS CPU. It is the consumer end of the device IRQ lines driven by the memory-mapped peripherals behind the system bridge; the timer at 0x7f10 drives HWInt[0].
- Samples the IRQ lines and masks them against SR.IM.
- Decides when the pipeline must trap, and records EPC, Cause.BD and Cause.ExcCode.
- Serves mfc0/mtc0 accesses to registers 12–15 and clears EXL on eret.

---
 rtl/cp0_intc.sv | 149 ++++++++++++++
 tb/tb_cp0_intc.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_intc.sv
`default_nettype none
// ============================================================================
// Module   : cp0_intc
// Purpose  : Coprocessor-0 interrupt / exception controller. Masks the
//            level-sensitive device IRQ lines against SR.IM, decides when
//            the pipeline must trap, captures EPC / Cause.BD /
//            Cause.ExcCode, and serves mfc0/mtc0 for CP0 registers 12-15.
//            eret (EXLClr) returns the controller to the NORMAL state.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous active-low reset
//            Addr     - CP0 register number for mfc0/mtc0
//            WE       - mtc0 write strobe
//            DataIn   - mtc0 write data
//            DataOut  - mfc0 read data (combinational on Addr)
//            HWInt    - device interrupt lines, bit0 = timer
//            VPC      - PC of the instruction at the commit point
//            BD       - victim instruction is in a branch delay slot
//            ExcCode  - synchronous exception code, 0 = none
//            EXLClr   - eret retiring this cycle
//            IntReq   - trap request to the pipeline
//            EPC      - current EPC (eret target)
// Revision : 1.0 - initial release
// ============================================================================
module cp0_intc #(
  parameter logic [31:0] PRID = 32'h0000_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  input  logic [5:0]  HWInt,
  input  logic [31:0] VPC,
  input  logic        BD,
  input  logic [4:0]  ExcCode,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC
);

  localparam logic [4:0] C_ADDR_SR    = 5'd12;
  localparam logic [4:0] C_ADDR_CAUSE = 5'd13;
  localparam logic [4:0] C_ADDR_EPC   = 5'd14;
  localparam logic [4:0] C_ADDR_PRID  = 5'd15;

  // The operating state is exactly SR.EXL.
  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  im_q, im_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [5:0]  ip_q, ip_d;
  logic [31:0] epc_q, epc_d;

  logic        w_exl;
  logic        w_int;
  logic        w_exc;
  logic        w_trap;
  logic [31:0] w_victim_pc;
  logic [31:0] w_sr;
  logic [31:0] w_cause;

  assign w_exl  = (state_q == HANDLER);
  // Trap decision uses the live IRQ lines, not the sampled IP field.
  assign w_int  = (|(HWInt & im_q)) & ie_q & ~w_exl;
  assign w_exc  = (ExcCode != 5'd0) & ~w_exl;
  assign w_trap = w_int | w_exc;

  // Delay-slot victims restart at the branch; wraps naturally at 0.
  assign w_victim_pc = VPC - (BD ? 32'd4 : 32'd0);

  assign w_sr    = {16'b0, im_q, 8'b0, w_exl, ie_q};
  assign w_cause = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};

  assign IntReq = w_trap;
  assign EPC    = epc_q;

  always_comb begin
    DataOut = 32'd0;
    case (Addr)
      C_ADDR_SR:    DataOut = w_sr;
      C_ADDR_CAUSE: DataOut = w_cause;
      C_ADDR_EPC:   DataOut = epc_q;
      C_ADDR_PRID:  DataOut = PRID;
      default:      DataOut = 32'd0;
    endcase
  end

  // Sources are applied lowest priority first so that a higher-priority
  // source overwrites only the fields it owns (trap > eret > mtc0).
  always_comb begin
    state_d   = state_q;
    im_d      = im_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ip_d      = HWInt;

    if (WE) begin
      if (Addr == C_ADDR_SR) begin
        im_d    = DataIn[15:10];
        ie_d    = DataIn[0];
        state_d = DataIn[1] ? HANDLER : NORMAL;
      end else if (Addr == C_ADDR_EPC) begin
        epc_d = DataIn & 32'hFFFF_FFFC;
      end
    end

    if (EXLClr) begin
      state_d = NORMAL;
    end

    if (w_trap) begin
      state_d   = HANDLER;
      bd_d      = BD;
      exccode_d = w_int ? 5'd0 : ExcCode;
      epc_d     = w_victim_pc & 32'hFFFF_FFFC;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= NORMAL;
      im_q      <= 6'd0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      exccode_q <= 5'd0;
      ip_q      <= 6'd0;
      epc_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      im_q      <= im_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      exccode_q <= exccode_d;
      ip_q      <= ip_d;
      epc_q     <= epc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0_intc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_intc
// Purpose  : Self-checking bench for cp0_intc. Directed scenarios followed
//            by randomized traffic, all compared against a word-level
//            reference model of the CP0 registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_intc;

  localparam logic [31:0] C_PRID = 32'h0000_0007;

  logic        clk;
  logic        reset;
  logic [4:0]  Addr;
  logic        WE;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic [5:0]  HWInt;
  logic [31:0] VPC;
  logic        BD;
  logic [4:0]  ExcCode;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;

  int checks_total;
  int checks_passed;

  // Reference model: whole architectural register words.
  logic [31:0] m_sr;
  logic [31:0] m_cause;
  logic [31:0] m_epc;

  cp0_intc #(.PRID(C_PRID)) dut (
    .clk     (clk),
    .reset   (reset),
    .Addr    (Addr),
    .WE      (WE),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .HWInt   (HWInt),
    .VPC     (VPC),
    .BD      (BD),
    .ExcCode (ExcCode),
    .EXLClr  (EXLClr),
    .IntReq  (IntReq),
    .EPC     (EPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic m_is_int();
    return (((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1]);
  endfunction

  function automatic logic m_is_trap();
    return m_is_int() || ((ExcCode != 5'd0) && !m_sr[1]);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return C_PRID;
      default: return 32'd0;
    endcase
  endfunction

  // One clock: check the combinational outputs against the model, then
  // advance the model by the register rules at the rising edge.
  task automatic cycle();
    logic        trap;
    logic        intr;
    logic [31:0] n_sr, n_cause, n_epc;
    #1;
    trap = m_is_trap();
    intr = m_is_int();
    check("intreq",  {31'd0, IntReq}, {31'd0, trap});
    check("dataout", DataOut, m_read(Addr));
    check("epc",     EPC, m_epc);
    @(posedge clk);
    n_sr    = m_sr;
    n_cause = m_cause;
    n_epc   = m_epc;
    n_cause[15:10] = HWInt;
    if (WE && Addr == 5'd12) n_sr  = DataIn & 32'h0000_FC03;
    if (WE && Addr == 5'd14) n_epc = DataIn & 32'hFFFF_FFFC;
    if (EXLClr && !trap)     n_sr[1] = 1'b0;
    if (trap) begin
      n_sr[1]       = 1'b1;
      n_cause[31]   = BD;
      n_cause[6:2]  = intr ? 5'd0 : ExcCode;
      n_epc         = (BD ? (VPC - 32'd4) : VPC) & 32'hFFFF_FFFC;
    end
    m_sr    = n_sr;
    m_cause = n_cause;
    m_epc   = n_epc;
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; DataIn = 32'd0; HWInt = 6'd0; VPC = 32'd0;
    BD = 1'b0; ExcCode = 5'd0; EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    Addr = a; WE = 1'b1; DataIn = d;
    cycle();
    WE = 1'b0;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    reset = 1'b0;
    Addr  = 5'd15;
    idle_inputs();

    // Reset state
    #2;
    check("rst_prid", DataOut, C_PRID);
    Addr = 5'd12; #1; check("rst_sr", DataOut, 32'd0);
    check("rst_intreq", {31'd0, IntReq}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Basic interrupt
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; VPC = 32'h0000_3010; BD = 1'b0; Addr = 5'd12;
    #1; check("basic_intreq", {31'd0, IntReq}, 32'd1);
    cycle();
    check("basic_sr",  DataOut, 32'h0000_0403);
    check("basic_epc", EPC, 32'h0000_3010);
    Addr = 5'd13; #1; check("basic_cause", DataOut, 32'h0000_0400);
    check("basic_intreq_off", {31'd0, IntReq}, 32'd0);
    cycle();

    // Delay-slot exception with IE=0
    HWInt = 6'd0;
    mtc0(5'd12, 32'h0000_0000);
    ExcCode = 5'd12; BD = 1'b1; VPC = 32'h0000_3024;
    cycle();
    ExcCode = 5'd0; BD = 1'b0; Addr = 5'd13;
    #1;
    check("ds_epc",   EPC, 32'h0000_3020);
    check("ds_cause", DataOut, 32'h8000_0030);
    cycle();

    // Interrupt and exception together
    mtc0(5'd12, 32'h0000_0401);
    HWInt = 6'b000001; ExcCode = 5'd4; VPC = 32'h0000_3100; BD = 1'b0;
    cycle();
    HWInt = 6'd0; ExcCode = 5'd0; Addr = 5'd13;
    #1;
    check("ie_exccode", {27'd0, DataOut[6:2]}, 32'd0);
    check("ie_epc",     EPC, 32'h0000_3100);
    cycle();

    // Masking
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'h3F; Addr = 5'd13; VPC = 32'h0000_3200;
    #1; check("mask_intreq", {31'd0, IntReq}, 32'd0);
    cycle();
    check("mask_ip", {26'd0, DataOut[15:10]}, 32'h3F);
    mtc0(5'd12, 32'h0000_8001);
    check("mask_open_intreq", {31'd0, IntReq}, 32'd1);
    cycle();

    // eret race: EXL=1, HWInt pending, eret clears EXL
    EXLClr = 1'b1; Addr = 5'd12; VPC = 32'h0000_3300;
    cycle();
    check("eret_sr", DataOut, 32'h0000_8001);
    check("eret_reraise", {31'd0, IntReq}, 32'd1);
    // Trap and eret on the same edge with EXL=0: EXL stays set
    cycle();
    EXLClr = 1'b0;
    check("race_sr", DataOut, 32'h0000_8003);
    cycle();

    // EPC wrap: delay-slot victim at address 0
    HWInt = 6'd0;
    mtc0(5'd12, 32'h0000_0000);
    ExcCode = 5'd1; BD = 1'b1; VPC = 32'h0000_0000;
    cycle();
    ExcCode = 5'd0; BD = 1'b0;
    check("wrap_epc", EPC, 32'hFFFF_FFFC);
    cycle();

    // Asynchronous reset mid-cycle with EXL=1, EPC=0x3000
    mtc0(5'd14, 32'h0000_3000);
    Addr = 5'd12; cycle();
    check("pre_rst_epc", EPC, 32'h0000_3000);
    #2; reset = 1'b0;
    #1; check("arst_sr", DataOut, 32'd0);
    Addr = 5'd13; #1; check("arst_cause", DataOut, 32'd0);
    Addr = 5'd14; #1; check("arst_epc_reg", DataOut, 32'd0);
    check("arst_epc", EPC, 32'd0);
    Addr = 5'd15; #1; check("arst_prid", DataOut, C_PRID);
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    @(posedge clk); #1;
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                       : 5'($urandom_range(12, 15));
      Addr    = a;
      WE      = ($urandom_range(0, 3) == 0);
      DataIn  = $urandom;
      HWInt   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      VPC     = $urandom;
      BD      = 1'($urandom);
      ExcCode = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
      EXLClr  = ($urandom_range(0, 3) == 0);
      cycle();
    end
    idle_inputs();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
